// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - mm:ss BCD countdown timer with prescaled tick, pause and expiry flags
module bcd_countdown_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] times,
  output logic        time_out,
  output logic        done,
  output logic        running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], 4'd9), clamp_digit(v[11:8], 4'd9),
            clamp_digit(v[7:4], 4'd5), clamp_digit(v[3:0], 4'd9)};
  endfunction

  // Ripple-borrow decrement; callers never pass 00:00.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    m10 = v[15:12];
    m1  = v[11:8];
    s10 = v[7:4];
    s1  = v[3:0];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      times    <= 16'h0000;
      time_out <= 1'b0;
      done     <= 1'b0;
      running  <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (load) begin
        state   <= IDLE;
        presc   <= '0;
        times   <= clamp_bcd(preset);
        done    <= 1'b0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (times != 16'h0000)) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          // PAUSED with pause released counts this cycle too, so no partial tick is lost.
          RUN, PAUSED: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (times == 16'h0001) begin
                times    <= 16'h0000;
                time_out <= 1'b1;
                done     <= 1'b1;
                running  <= 1'b0;
                state    <= EXPIRED;
              end else begin
                times   <= dec_bcd(times);
                state   <= RUN;
                running <= 1'b1;
              end
            end else begin
              presc   <= presc + 1'b1;
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state <= EXPIRED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer (DIV=4)
module tb_bcd_countdown_timer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] preset;
  logic        start;
  logic        pause;
  logic [15:0] times;
  logic        time_out;
  logic        done;
  logic        running;

  int checks;
  int failures;

  bcd_countdown_timer #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .preset   (preset),
    .start    (start),
    .pause    (pause),
    .times    (times),
    .time_out (time_out),
    .done     (done),
    .running  (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load   = 1'b1;
    preset = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Returns at the negedge following the edge that sampled start (call that edge E0).
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    load     = 1'b0;
    preset   = 16'h0000;
    start    = 1'b0;
    pause    = 1'b0;

    // 1: reset state, then 00:03 countdown to expiry
    cyc(2);
    chk("rst_times", times, 16'h0000);
    chk("rst_flags", {13'd0, time_out, done, running}, 16'h0000);
    rst = 1'b1;
    cyc(1);
    do_load(16'h0003);
    chk("t1_load", times, 16'h0003);
    do_start();
    chk("t1_running", {15'd0, running}, 16'h0001);
    cyc(3);
    chk("t1_e3", times, 16'h0003);
    cyc(1);
    chk("t1_e4", times, 16'h0002);
    cyc(4);
    chk("t1_e8", times, 16'h0001);
    cyc(3);
    chk("t1_e11_to", {15'd0, time_out}, 16'h0000);
    cyc(1);
    chk("t1_e12_times", times, 16'h0000);
    chk("t1_e12_flags", {13'd0, time_out, done, running}, 16'h0006);
    cyc(1);
    chk("t1_e13_flags", {13'd0, time_out, done, running}, 16'h0002);

    // 2: minute borrow 10:00 -> 09:59 -> 09:58, and 01:00 -> 00:59
    do_load(16'h1000);
    chk("t2_done_clr", {15'd0, done}, 16'h0000);
    do_start();
    cyc(4);
    chk("t2_tick1", times, 16'h0959);
    cyc(4);
    chk("t2_tick2", times, 16'h0958);
    do_load(16'h0100);
    do_start();
    cyc(4);
    chk("t2_0100", times, 16'h0059);

    // 3: pause from E2 through E11, first decrement at E14
    do_load(16'h0002);
    do_start();
    cyc(1);
    pause = 1'b1;
    cyc(1);
    chk("t3_paused_run", {15'd0, running}, 16'h0000);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    chk("t3_frozen", times, 16'h0002);
    chk("t3_still_paused", {15'd0, running}, 16'h0000);
    pause = 1'b0;
    cyc(2);
    chk("t3_e13", times, 16'h0002);
    chk("t3_resumed", {15'd0, running}, 16'h0001);
    cyc(1);
    chk("t3_e14", times, 16'h0001);

    // 4: clamp on load, zero preset cannot start
    do_load(16'h9F7C);
    chk("t4_clamp", times, 16'h9959);
    do_load(16'h0000);
    do_start();
    chk("t4_zero_idle", {13'd0, time_out, done, running}, 16'h0000);
    cyc(5);
    chk("t4_zero_hold", {times[12:0], time_out, done, running}, 16'h0000);

    // 5: load beats the expiring tick; then EXPIRED ignores start and pause
    do_load(16'h0001);
    do_start();
    cyc(3);
    do_load(16'h0030);
    chk("t5_load_wins", times, 16'h0030);
    chk("t5_no_pulse", {13'd0, time_out, done, running}, 16'h0000);
    cyc(6);
    chk("t5_idle_hold", times, 16'h0030);
    do_load(16'h0001);
    do_start();
    cyc(4);
    chk("t5_expired", {13'd0, time_out, done, running}, 16'h0006);
    do_start();
    pause = 1'b1;
    cyc(2);
    pause = 1'b0;
    do_start();
    chk("t5_exp_times", times, 16'h0000);
    chk("t5_exp_flags", {13'd0, time_out, done, running}, 16'h0002);

    // 6: asynchronous reset in the middle of a run
    do_load(16'h0025);
    do_start();
    cyc(2);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_times", times, 16'h0000);
    chk("t6_async_flags", {13'd0, time_out, done, running}, 16'h0000);
    cyc(1);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t6_after_rel", {times[12:0], time_out, done, running}, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
